sbox_cfg_ctrl: RTL and testbench
================================

SBOX_CFG_CTRL -- requirements
Module: sbox_cfg_ctrl

Interface
REQ-001 Parameter NUM_SBOX, default 4: number of switch boxes configured per frame; legal range 1..16.
REQ-002 Parameter SEL_W, default 2: width of one direction select.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin a configuration frame.
REQ-006 abort  in  1  terminate the frame in progress.
REQ-007 cfg_valid  in  1  cfg_data holds a valid word.
REQ-008 cfg_data  in  4*SEL_W  one word per sbox; fields {e,s,w,n}, north in the LSBs.
REQ-009 cfg_ready  out  1  block can accept a word this cycle.
REQ-010 cfg_en  out  NUM_SBOX  one-hot write enable to the target sbox config registers.
REQ-011 cfg_sel  out  4*SEL_W  write data broadcast to all sboxes.
REQ-012 busy  out  1  a frame is in progress.
REQ-013 done  out  1  one-cycle pulse on frame completion.
REQ-014 err  out  1  sticky protocol error flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, LOAD and FINISH.
REQ-016 IDLE -> LOAD on start=1; index cleared to 0; busy=1 from the next cycle.
REQ-017 In LOAD, cfg_ready=1 unless abort=1; in IDLE and FINISH, cfg_ready=0.
REQ-018 Transfer occurs when cfg_valid & cfg_ready; a word offered outside LOAD is not consumed and is not an error.
REQ-019 Each transfer SHALL register cfg_sel=cfg_data and assert cfg_en bit [index] for exactly the next cycle (latency 1); otherwise cfg_en=0 and cfg_sel holds its last value.
REQ-020 Index increments per transfer; the transfer at index NUM_SBOX-1 moves the FSM to FINISH and wraps the index to 0.
REQ-021 FINISH lasts one cycle, asserts done=1, deasserts busy, then returns to IDLE.
REQ-022 start=1 in LOAD or FINISH SHALL be ignored and SHALL set err.
REQ-023 abort=1 in LOAD returns the FSM to IDLE next cycle with no done; a transfer coincident with abort is not accepted; already-written sboxes keep their values.
REQ-024 abort in IDLE or FINISH has no effect; start and abort together in IDLE gives abort priority (stay IDLE).
REQ-025 err clears only on reset or on start accepted in IDLE.

Reset
REQ-026 On reset low: state=IDLE, index=0, cfg_ready=0, cfg_en=0, cfg_sel=0, busy=0, done=0, err=0, applied immediately without waiting for clk.
REQ-027 Reset during LOAD abandons the frame; no cfg_en pulse follows reset deassertion.

Configuration
REQ-028 Macro SBOX_CFG_READBACK_EN: when defined, adds rd_idx in ($clog2(NUM_SBOX), min 1) and rd_data out (4*SEL_W), a shadow register per sbox updated on its cfg_en pulse and reset to 0; rd_data is combinational from rd_idx; an out-of-range rd_idx returns 0.
REQ-029 Without SBOX_CFG_READBACK_EN, the rd_idx/rd_data ports and shadow registers SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package sbox_cfg_pkg SHALL hold SEL_W, the direction codes DIR_N=0, DIR_W=1, DIR_S=2, DIR_E=3, and the FSM state enum.
REQ-031 One sub-module, sbox_cfg_idx, SHALL implement the wrapping index counter with clear, increment and last-index flag.

Verification
REQ-032 NUM_SBOX=4, start, then words 0xE4,0x1B,0x00,0xFF back-to-back -> cfg_en 0001,0010,0100,1000 on consecutive cycles with matching cfg_sel; done pulses once; busy low after.
REQ-033 cfg_valid toggled 1,0,1,0 in LOAD -> exactly one cfg_en pulse per accepted word; index does not advance on idle cycles.
REQ-034 start during LOAD after 2 words -> err=1; frame completes normally at word 4; the next start in IDLE clears err.
REQ-035 abort after 2 words with cfg_valid=1 -> no 3rd cfg_en, no done, IDLE next cycle; with SBOX_CFG_READBACK_EN, rd_idx=1 returns word 2 and rd_idx=2 returns 0.
REQ-036 reset low asynchronously mid-LOAD -> all outputs 0 immediately; after release, cfg_valid=1 without start yields cfg_ready=0 and no cfg_en.

Source files
------------

// File: rtl/sbox_cfg_pkg.sv
// Shared constants and FSM state type for the switch-box configuration controller.
package sbox_cfg_pkg;

    localparam int unsigned SEL_W = 2;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_E = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
    } state_e;

endpackage

// File: rtl/sbox_cfg_idx.sv
// Wrapping switch-box index counter with synchronous clear, increment and
// a flag marking the last switch box of a frame.
module sbox_cfg_idx #(
    parameter int unsigned NUM_SBOX = 4,
    parameter int unsigned IDX_W    = (NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    import sbox_cfg_pkg::*;

    assign last = (idx == IDX_W'(NUM_SBOX - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/sbox_cfg_ctrl.sv
// Streams one configuration word per switch box into per-sbox registers.
// Optional macro SBOX_CFG_READBACK_EN adds shadow registers and rd_idx/rd_data readback.
module sbox_cfg_ctrl #(
    parameter int unsigned NUM_SBOX = 4,
    parameter int unsigned SEL_W    = sbox_cfg_pkg::SEL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_valid,
    input  logic [4*SEL_W-1:0]    cfg_data,
    output logic                  cfg_ready,
    output logic [NUM_SBOX-1:0]   cfg_en,
    output logic [4*SEL_W-1:0]    cfg_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef SBOX_CFG_READBACK_EN
    ,
    input  logic [((NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1)-1:0] rd_idx,
    output logic [4*SEL_W-1:0]    rd_data
`endif
);
    import sbox_cfg_pkg::*;

    localparam int unsigned IDX_W = (NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1;
    localparam int unsigned DW    = 4 * SEL_W;

    state_e              state;
    state_e              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic                idx_last;
    logic                idx_clr;
    logic                xfer;
    logic                err_set;
    logic                err_clr;
    logic [NUM_SBOX-1:0] en_nxt;

    sbox_cfg_idx #(
        .NUM_SBOX (NUM_SBOX),
        .IDX_W    (IDX_W)
    ) u_idx (
        .clk   (clk),
        .reset (reset),
        .clr   (idx_clr),
        .inc   (xfer),
        .idx   (idx),
        .last  (idx_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        idx_clr   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = LOAD;
                    idx_clr   = 1'b1;
                    err_clr   = 1'b1;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                cfg_ready = !abort;
                err_set   = start;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cfg_valid && idx_last) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                err_set   = start;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer = cfg_valid & cfg_ready;

    always_comb begin
        en_nxt = '0;
        for (int unsigned i = 0; i < NUM_SBOX; i++) begin
            en_nxt[i] = xfer && (32'(idx) == i);
        end
    end

    // cfg_sel only moves on a transfer so sboxes see stable data between frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_en  <= '0;
            cfg_sel <= '0;
        end else begin
            cfg_en <= en_nxt;
            if (xfer) begin
                cfg_sel <= cfg_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (err_clr) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

`ifdef SBOX_CFG_READBACK_EN
    logic [DW-1:0] shadow [NUM_SBOX];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_SBOX; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SBOX; i++) begin
                if (cfg_en[i]) begin
                    shadow[i] <= cfg_sel;
                end
            end
        end
    end

    // Unmatched (out-of-range) indices fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_SBOX; i++) begin
            if (32'(rd_idx) == i) begin
                rd_data = shadow[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sbox_cfg_ctrl.sv
// Scoreboard bench for sbox_cfg_ctrl; readback checks compile in with SBOX_CFG_READBACK_EN.
module tb_sbox_cfg_ctrl;
    import sbox_cfg_pkg::*;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int DW = 4 * SW;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [DW-1:0] cfg_data  = '0;
    logic          cfg_ready;
    logic [NS-1:0] cfg_en;
    logic [DW-1:0] cfg_sel;
    logic          busy;
    logic          done;
    logic          err;
`ifdef SBOX_CFG_READBACK_EN
    logic [1:0]    rd_idx = '0;
    logic [DW-1:0] rd_data;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int en_cnt = 0;

    typedef struct packed {
        logic [NS-1:0] en;
        logic [DW-1:0] sel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sbox_cfg_ctrl #(
        .NUM_SBOX (NS),
        .SEL_W    (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_en    (cfg_en),
        .cfg_sel   (cfg_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef SBOX_CFG_READBACK_EN
        ,
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
`endif
    );

    always #5 clk = ~clk;

    // Every cfg_en pulse must match the oldest expected transfer.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (done === 1'b1) done_cnt++;
            if (cfg_en !== '0) begin
                en_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_cfg_en: got en=%b sel=%h, required no pulse", cfg_en, cfg_sel);
                end else begin
                    mon_e = sb.pop_front();
                    if (cfg_en !== mon_e.en || cfg_sel !== mon_e.sel) begin
                        bad++;
                        $display("FAIL cfg_en_pulse: got en=%b sel=%h, required en=%b sel=%h",
                                 cfg_en, cfg_sel, mon_e.en, mon_e.sel);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [DW-1:0] w);
        exp_t e;
        e.en  = NS'(1 << k);
        e.sel = w;
        sb.push_back(e);
        cfg_valid = 1'b1;
        cfg_data  = w;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if ({cfg_ready, busy, done, err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got ready/busy/done/err=%b, required 0000", {cfg_ready, busy, done, err});
        end
        total++;
        if (cfg_en !== '0 || cfg_sel !== '0) begin
            bad++;
            $display("FAIL reset_regs: got en=%b sel=%h, required 0/00", cfg_en, cfg_sel);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [4];
        int d0;
        words[0] = 8'hE4; words[1] = 8'h1B; words[2] = 8'h00; words[3] = 8'hFF;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_load_entry: got busy=%b ready=%b, required 1 1", busy, cfg_ready);
        end
        for (int k = 0; k < 4; k++) send(k, words[k]);
        cfg_valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_finish: got done=%b busy=%b ready=%b, required 1 0 0", done, busy, cfg_ready);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got done=%b busy=%b, required 0 0", done, busy);
        end
        tick();
        total++;
        if (done_cnt - d0 != 1 || sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_counts: got done pulses=%0d pending=%0d, required 1 0", done_cnt - d0, sb.size());
        end
    endtask

    task automatic test_valid_toggle();
        int d0, e0;
        d0 = done_cnt;
        e0 = en_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                send(i / 2, DW'(8'h10 + i));
            end else begin
                cfg_valid = 1'b0;
                cfg_data  = 8'hAA;
                tick();
            end
        end
        tick();
        total++;
        if (en_cnt - e0 != 4 || done_cnt - d0 != 1 || sb.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL toggle_counts: got en=%0d done=%0d pending=%0d busy=%b, required 4 1 0 0",
                     en_cnt - e0, done_cnt - d0, sb.size(), busy);
        end
    endtask

    task automatic test_err();
        start = 1'b1;
        tick();
        start = 1'b0;
        send(0, 8'h21);
        send(1, 8'h42);
        cfg_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL err_set: got err=%b busy=%b, required 1 1", err, busy);
        end
        send(2, 8'h84);
        send(3, 8'h18);
        cfg_valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || err !== 1'b1) begin
            bad++;
            $display("FAIL err_finish: got done=%b err=%b, required 1 1", done, err);
        end
        tick();
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL err_sticky: got err=%b busy=%b, required 1 0", err, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL err_clear: got err=%b busy=%b, required 0 1", err, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL abort_priority_idle: got busy=%b err=%b, required 0 0", busy, err);
        end
    endtask

    task automatic test_abort();
        int d0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send(0, 8'h3C);
        send(1, 8'hC3);
        cfg_valid = 1'b1;
        cfg_data  = 8'h99;
        abort = 1'b1;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_ready: got %b, required 0", cfg_ready);
        end
        tick();
        abort = 1'b0;
        cfg_valid = 1'b0;
        total++;
        if (cfg_en !== '0 || cfg_sel !== 8'hC3 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got en=%b sel=%h busy=%b done=%b, required 0000 c3 0 0",
                     cfg_en, cfg_sel, busy, done);
        end
        tick();
        tick();
        total++;
        if (done_cnt != d0 || sb.size() != 0) begin
            bad++;
            $display("FAIL abort_no_done: got done pulses=%0d pending=%0d, required 0 0", done_cnt - d0, sb.size());
        end
`ifdef SBOX_CFG_READBACK_EN
        rd_idx = 2'd1;
        #1;
        total++;
        if (rd_data !== 8'hC3) begin
            bad++;
            $display("FAIL readback_idx1: got %h, required c3", rd_data);
        end
        rd_idx = 2'd2;
        #1;
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("FAIL readback_idx2: got %h, required 00", rd_data);
        end
        rd_idx = 2'd0;
        #1;
        total++;
        if (rd_data !== 8'h3C) begin
            bad++;
            $display("FAIL readback_idx0: got %h, required 3c", rd_data);
        end
`endif
    endtask

    task automatic test_async_reset();
        int e0;
        start = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        send(0, 8'h5A);
        cfg_valid = 1'b0;
        tick();
        #2;
        total++;
        if (err !== 1'b1 || busy !== 1'b1 || cfg_sel !== 8'h5A) begin
            bad++;
            $display("FAIL pre_reset_state: got err=%b busy=%b sel=%h, required 1 1 5a", err, busy, cfg_sel);
        end
        e0 = en_cnt;
        reset = 1'b0;
        #1;
        total++;
        if ({cfg_ready, busy, done, err} !== 4'b0000 || cfg_en !== '0 || cfg_sel !== '0) begin
            bad++;
            $display("FAIL async_reset: got ready/busy/done/err=%b en=%b sel=%h, required 0000 0000 00",
                     {cfg_ready, busy, done, err}, cfg_en, cfg_sel);
        end
        tick();
        #2;
        reset = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cfg_ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle: got ready=%b busy=%b, required 0 0", cfg_ready, busy);
            end
        end
        cfg_valid = 1'b0;
        tick();
        total++;
        if (en_cnt != e0 || sb.size() != 0) begin
            bad++;
            $display("FAIL post_reset_no_en: got pulses=%0d pending=%0d, required 0 0", en_cnt - e0, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_valid_toggle();
        test_err();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
